// File: rtl/mmu_table_walk.sv
// ============================================================================
// Module   : mmu_table_walk
// Purpose  : ARM9-style two-level translation table walker (L1 then optional L2)
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmu_table_walk (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] mva,
    input  logic [17:0] ttb,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] paddr,
    output logic [3:0]  fault_status
);

    localparam logic [3:0] FS_SECTION = 4'b0101;
    localparam logic [3:0] FS_PAGE    = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q;
    logic [19:0] mva_q;
    logic        coarse_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic        busy_q;
    logic        done_q;
    logic        fault_q;
    logic [31:0] paddr_q;
    logic [3:0]  fault_status_q;

    // Permission, domain and cache fields of the descriptor play no part here.
    logic w_unused_desc;
    assign w_unused_desc = &{1'b0, mem_rdata[9:2]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mva_q          <= 20'd0;
            coarse_q       <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= 32'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fault_q        <= 1'b0;
            paddr_q        <= 32'd0;
            fault_status_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mva_q      <= mva[19:0];
                        mem_addr_q <= {ttb, mva[31:20], 2'b00};
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= L1;
                    end
                end
                L1: begin
                    if (mem_ack) begin
                        case (mem_rdata[1:0])
                            2'b00: begin
                                mem_req_q      <= 1'b0;
                                busy_q         <= 1'b0;
                                fault_q        <= 1'b1;
                                fault_status_q <= FS_SECTION;
                                state_q        <= RESP;
                            end
                            2'b10: begin
                                mem_req_q <= 1'b0;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                paddr_q   <= {mem_rdata[31:20], mva_q[19:0]};
                                state_q   <= RESP;
                            end
                            2'b01: begin
                                mem_addr_q <= {mem_rdata[31:10], mva_q[19:12], 2'b00};
                                coarse_q   <= 1'b1;
                                state_q    <= L2;
                            end
                            default: begin
                                mem_addr_q <= {mem_rdata[31:12], mva_q[19:10], 2'b00};
                                coarse_q   <= 1'b0;
                                state_q    <= L2;
                            end
                        endcase
                    end
                end
                L2: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= RESP;
                        case (mem_rdata[1:0])
                            2'b01: begin
                                done_q  <= 1'b1;
                                paddr_q <= {mem_rdata[31:16], mva_q[15:0]};
                            end
                            2'b10: begin
                                done_q  <= 1'b1;
                                paddr_q <= {mem_rdata[31:12], mva_q[11:0]};
                            end
                            2'b11: begin
                                // Tiny pages exist only in fine tables.
                                if (coarse_q) begin
                                    fault_q        <= 1'b1;
                                    fault_status_q <= FS_PAGE;
                                end else begin
                                    done_q  <= 1'b1;
                                    paddr_q <= {mem_rdata[31:10], mva_q[9:0]};
                                end
                            end
                            default: begin
                                fault_q        <= 1'b1;
                                fault_status_q <= FS_PAGE;
                            end
                        endcase
                    end
                end
                RESP: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fault        = fault_q;
    assign paddr        = paddr_q;
    assign fault_status = fault_status_q;

endmodule

`default_nettype wire

// File: tb/tb_mmu_table_walk.sv
// ============================================================================
// Module   : tb_mmu_table_walk
// Purpose  : Directed self-checking bench for the translation table walker
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mmu_table_walk;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] mva;
    logic [17:0] ttb;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] paddr;
    logic [3:0]  fault_status;

    int vectors;
    int miscompares;

    mmu_table_walk dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mva          (mva),
        .ttb          (ttb),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .paddr        (paddr),
        .fault_status (fault_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of cycle 1.
    task automatic issue(input logic [17:0] t, input logic [31:0] m);
        start = 1'b1;
        ttb   = t;
        mva   = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        chk({tag, " req"}, mem_req, 1);
        chk({tag, " busy"}, busy, 1);
        chk({tag, " addr"}, mem_addr, exp_addr);
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic expect_done(input string tag, input logic [31:0] exp_paddr);
        chk({tag, " done"}, done, 1);
        chk({tag, " fault"}, fault, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " req"}, mem_req, 0);
        chk({tag, " paddr"}, paddr, exp_paddr);
        @(negedge clk);
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " req after"}, mem_req, 0);
    endtask

    task automatic expect_fault(input string tag, input logic [3:0] exp_fs);
        chk({tag, " fault"}, fault, 1);
        chk({tag, " done"}, done, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " req"}, mem_req, 0);
        chk({tag, " status"}, {28'd0, fault_status}, {28'd0, exp_fs});
        @(negedge clk);
        chk({tag, " fault pulse"}, fault, 0);
        chk({tag, " req after"}, mem_req, 0);
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        mva         = 32'd0;
        ttb         = 18'd0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst req",    mem_req, 0);
        chk("rst busy",   busy, 0);
        chk("rst done",   done, 0);
        chk("rst fault",  fault, 0);
        chk("rst addr",   mem_addr, 0);
        chk("rst paddr",  paddr, 0);
        chk("rst status", {28'd0, fault_status}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Section mapping, zero-wait memory.
        issue(18'h00001, 32'h0010_0123);
        serve("sec L1", 32'h0000_4004, 32'h8000_0002);
        expect_done("sec", 32'h8000_0123);

        // Coarse table, small page.
        issue(18'h00001, 32'h0010_5ABC);
        serve("csmall L1", 32'h0000_4004, 32'h0000_8001);
        serve("csmall L2", 32'h0000_8014, 32'h1234_5002);
        expect_done("csmall", 32'h1234_5ABC);

        // Coarse table, large page.
        issue(18'h00001, 32'h0010_5ABC);
        serve("clarge L1", 32'h0000_4004, 32'h0000_8001);
        serve("clarge L2", 32'h0000_8014, 32'hABCD_0001);
        expect_done("clarge", 32'hABCD_5ABC);

        // Fine table, tiny page.
        issue(18'h00001, 32'h0010_5ABC);
        serve("ftiny L1", 32'h0000_4004, 32'h0000_9003);
        serve("ftiny L2", 32'h0000_9058, 32'h4444_4403);
        expect_done("ftiny", 32'h4444_46BC);

        // Faults.
        issue(18'h00001, 32'h0010_0123);
        serve("l1f L1", 32'h0000_4004, 32'h0000_0000);
        expect_fault("l1f", 4'b0101);

        issue(18'h00001, 32'h0010_5ABC);
        serve("ctiny L1", 32'h0000_4004, 32'h0000_8001);
        serve("ctiny L2", 32'h0000_8014, 32'h0000_0003);
        expect_fault("ctiny", 4'b0111);

        issue(18'h00001, 32'h0010_5ABC);
        serve("l2f L1", 32'h0000_4004, 32'h0000_8001);
        serve("l2f L2", 32'h0000_8014, 32'h0000_0000);
        expect_fault("l2f", 4'b0111);

        // Three wait cycles on the L1 read.
        issue(18'h2ABCD, 32'h7FF0_0010);
        for (int i = 0; i < 3; i++) begin
            chk("wait req",  mem_req, 1);
            chk("wait addr", mem_addr, 32'hAAF3_5FFC);
            chk("wait done", done, 0);
            @(negedge clk);
        end
        serve("wait L1", 32'hAAF3_5FFC, 32'h8000_0002);
        expect_done("wait", 32'h8000_0010);

        // Reset while the L2 read is outstanding.
        issue(18'h00001, 32'h0010_5ABC);
        serve("rstl2 L1", 32'h0000_4004, 32'h0000_8001);
        chk("rstl2 L2 req", mem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstl2 req",   mem_req, 0);
        chk("rstl2 busy",  busy, 0);
        chk("rstl2 done",  done, 0);
        chk("rstl2 fault", fault, 0);
        chk("rstl2 addr",  mem_addr, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5002;
        @(negedge clk);
        mem_ack   = 1'b0;
        chk("rstl2 stray done",  done, 0);
        chk("rstl2 stray fault", fault, 0);
        chk("rstl2 stray req",   mem_req, 0);
        chk("rstl2 stray busy",  busy, 0);
        @(negedge clk);
        chk("rstl2 idle done", done, 0);

        // Start pulse while busy must be ignored.
        issue(18'h00001, 32'h0010_0123);
        start = 1'b1;
        mva   = 32'hFFF0_0FFF;
        @(negedge clk);
        start = 1'b0;
        serve("busy L1", 32'h0000_4004, 32'h8000_0002);
        expect_done("busy", 32'h8000_0123);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) n++;
            chk("busy no req", mem_req, 0);
            @(negedge clk);
        end
        chk("busy extra done", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
